uart_hex_dec: RTL and testbench
===============================

UART_HEX_DEC -- requirements
Module: uart_hex_dec

Interface
REQ-001 The module SHALL have parameter ADDR_CHARS, default 2: number of ASCII address characters (>=1).
REQ-002 The module SHALL have parameter DATA_CHARS, default 8: number of ASCII data characters (>=1).
REQ-003 The module SHALL have parameter LOWER_EN, default 1: 1 accepts 'a'-'f' (0x61-0x66) as hex digits; 0 treats them as invalid.
REQ-004 The following are derived values, not ports: N = ADDR_CHARS+DATA_CHARS; IW = clog2(N+1).
REQ-005 The module SHALL have ports exactly as follows; it has one clock, and reset is synchronous and active-high:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- IN_VALID  in  1  input frame valid.
- IN_READY  out  1  module can accept a frame.
- STATE_R_IN  in  1  read-command flag.
- STATE_W_IN  in  1  write-command flag.
- ADDR_IN  in  8*ADDR_CHARS  ASCII address; top byte is the most significant character.
- DATA_IN  in  8*DATA_CHARS  ASCII data; top byte is the most significant character.
- FAIL_IN  in  1  upstream frame error.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts the result.
- STATE_R_OUT  out  1  registered copy of STATE_R_IN.
- STATE_W_OUT  out  1  registered copy of STATE_W_IN.
- ADDR_OUT  out  4*ADDR_CHARS  binary address.
- DATA_OUT  out  4*DATA_CHARS  binary data.
- FAIL_OUT  out  1  frame error.
- FAIL_IDX  out  IW  index of the first bad character.

Function
REQ-006 The module SHALL have FSM states IDLE, CONV and DONE; IN_READY SHALL be 1 only in IDLE, and OUT_VALID SHALL be 1 only in DONE.
REQ-007 In IDLE, on IN_VALID&&IN_READY the module SHALL capture {ADDR_IN,DATA_IN}, STATE_R_IN and STATE_W_IN, and clear the character counter cnt.
- If FAIL_IN=1 at capture, the module SHALL go to DONE with FAIL_OUT=1 and FAIL_IDX=N.
- Otherwise it SHALL go to CONV.
REQ-008 In CONV the module SHALL decode one character per cycle, starting with the most significant address character.
- Character index k = cnt: index 0 is the top byte of ADDR_IN, index N-1 is the bottom byte of DATA_IN.
- Each decoded nibble SHALL be shifted into the LSB end of a 4*N accumulator.
REQ-009 Valid characters SHALL be 0x30-0x39 -> 0-9 and 0x41-0x46 -> A-F, plus 0x61-0x66 -> A-F when LOWER_EN=1; every other byte is invalid.
REQ-010 An invalid character SHALL insert nibble 0.
- On the first invalid character of a frame, FAIL_IDX SHALL be set to cnt and the error flag set.
- Later invalid characters SHALL NOT change FAIL_IDX.
- Conversion SHALL continue to cnt=N-1; latency is fixed and does not depend on errors.
REQ-011 After the character at cnt=N-1, the module SHALL go to DONE and drive ADDR_OUT = accumulator[4N-1:4*DATA_CHARS] and DATA_OUT = accumulator[4*DATA_CHARS-1:0].
- FAIL_OUT SHALL equal the error flag; FAIL_IDX SHALL be 0 when no error occurred.
REQ-012 OUT_VALID SHALL rise N cycles after the accepting edge (1 cycle on the FAIL_IN path).
REQ-013 In DONE, all outputs SHALL be held stable until OUT_READY=1; the module SHALL then return to IDLE.
- Outputs keep their last values after the handshake.
- The next frame can be accepted on the following edge at the earliest.
REQ-014 IN_VALID SHALL be ignored outside IDLE; no frame SHALL be lost or merged.
REQ-015 All outputs SHALL be registered, except IN_READY, which is decoded from state.

Reset
REQ-016 When RST=1 at a CLK edge, the module SHALL go to IDLE and clear to 0: OUT_VALID, STATE_R_OUT, STATE_W_OUT, ADDR_OUT, DATA_OUT, FAIL_OUT, FAIL_IDX, cnt, the accumulator and the error flag.
REQ-017 RST SHALL have priority over all other inputs.
- Asserting RST during CONV or DONE SHALL discard the frame; no OUT_VALID SHALL follow for it.
- IN_READY SHALL be 1 on the cycle after RST is released.

Verification
REQ-018 The bench SHALL use defaults (N=10) and cover these directed scenarios:
- ADDR_IN="1F", DATA_IN="DEADBEEF", STATE_R_IN=1 -> OUT_VALID 10 cycles after accept; ADDR_OUT=0x1F, DATA_OUT=0xDEADBEEF, STATE_R_OUT=1, FAIL_OUT=0, FAIL_IDX=0.
- ADDR_IN="a5", DATA_IN="0000ffff" -> ADDR_OUT=0xA5, DATA_OUT=0x0000FFFF with LOWER_EN=1; with LOWER_EN=0 -> FAIL_OUT=1, FAIL_IDX=0.
- DATA_IN="123G56:8" with 'G' at index 5 and ':' at index 8 -> FAIL_OUT=1, FAIL_IDX=5, DATA_OUT=0x12305608, still at latency 10.
- FAIL_IN=1 with any payload -> OUT_VALID 1 cycle after accept, FAIL_OUT=1, FAIL_IDX=10.
- OUT_READY held 0 for 5 cycles in DONE -> outputs constant, IN_READY=0, a new IN_VALID is ignored; after OUT_READY=1, IN_READY=1 on the next cycle and the second frame decodes correctly.
- RST pulsed at cnt=4 -> next cycle IN_READY=1, OUT_VALID=0, all outputs 0, and no result is produced for the aborted frame.

Source files
------------

// File: rtl/uart_hex_dec.sv
// uart_hex_dec: turns a captured frame of ASCII hex characters into binary,
// one character per cycle, flagging the index of the first non-hex character.
module uart_hex_dec #(
  parameter int ADDR_CHARS = 2,
  parameter int DATA_CHARS = 8,
  parameter int LOWER_EN   = 1
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          IN_VALID,
  output logic                                          IN_READY,
  input  logic                                          STATE_R_IN,
  input  logic                                          STATE_W_IN,
  input  logic [8*ADDR_CHARS-1:0]                       ADDR_IN,
  input  logic [8*DATA_CHARS-1:0]                       DATA_IN,
  input  logic                                          FAIL_IN,
  output logic                                          OUT_VALID,
  input  logic                                          OUT_READY,
  output logic                                          STATE_R_OUT,
  output logic                                          STATE_W_OUT,
  output logic [4*ADDR_CHARS-1:0]                       ADDR_OUT,
  output logic [4*DATA_CHARS-1:0]                       DATA_OUT,
  output logic                                          FAIL_OUT,
  output logic [$clog2(ADDR_CHARS+DATA_CHARS+1)-1:0]    FAIL_IDX
);

  // state | meaning
  // IDLE  | waiting for a frame, IN_READY high
  // CONV  | decoding one character per cycle, most significant first
  // DONE  | result held until OUT_READY is seen with OUT_VALID high

  localparam int N  = ADDR_CHARS + DATA_CHARS;
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [8*N-1:0]      r_frame;
  logic [IW-1:0]       r_cnt;
  logic [4*N-5:0]      r_acc;
  logic                r_err;
  logic [IW-1:0]       r_idx;

  logic                r_out_valid;
  logic                r_state_r;
  logic                r_state_w;
  logic [4*ADDR_CHARS-1:0] r_addr_out;
  logic [4*DATA_CHARS-1:0] r_data_out;
  logic                r_fail_out;
  logic [IW-1:0]       r_fail_idx;

  logic [7:0]          w_char;
  logic [3:0]          w_nib;
  logic                w_char_ok;
  logic [4*N-1:0]      w_full;
  logic                w_last;

  assign w_char = r_frame[8*N-1 -: 8];
  assign w_full = {r_acc, w_nib};
  assign w_last = (r_cnt == IW'(N - 1));

  always_comb begin
    w_nib     = 4'd0;
    w_char_ok = 1'b0;
    if (w_char >= 8'h30 && w_char <= 8'h39) begin
      w_nib     = w_char[3:0];
      w_char_ok = 1'b1;
    end else if (w_char >= 8'h41 && w_char <= 8'h46) begin
      w_nib     = w_char[3:0] + 4'd9;
      w_char_ok = 1'b1;
    end else if (LOWER_EN != 0 && w_char >= 8'h61 && w_char <= 8'h66) begin
      w_nib     = w_char[3:0] + 4'd9;
      w_char_ok = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (IN_VALID) begin
          w_state_nxt = FAIL_IN ? DONE : CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (r_out_valid && OUT_READY) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame     <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_state_r   <= 1'b0;
      r_state_w   <= 1'b0;
      r_addr_out  <= '0;
      r_data_out  <= '0;
      r_fail_out  <= 1'b0;
      r_fail_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_frame   <= {ADDR_IN, DATA_IN};
            r_state_r <= STATE_R_IN;
            r_state_w <= STATE_W_IN;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            if (FAIL_IN) begin
              r_fail_out <= 1'b1;
              r_fail_idx <= IW'(N);
            end
          end
        end
        CONV: begin
          r_frame <= r_frame << 8;
          r_acc   <= w_full[4*N-5:0];
          r_cnt   <= r_cnt + IW'(1);
          if (!w_char_ok && !r_err) begin
            r_err <= 1'b1;
            r_idx <= r_cnt;
          end
          // Last character: publish the result straight from the shift path.
          if (w_last) begin
            r_addr_out  <= w_full[4*N-1:4*DATA_CHARS];
            r_data_out  <= w_full[4*DATA_CHARS-1:0];
            r_fail_out  <= r_err || !w_char_ok;
            r_fail_idx  <= r_err ? r_idx : (w_char_ok ? '0 : r_cnt);
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // The FAIL_IN path enters DONE with OUT_VALID low; it rises one cycle later.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign IN_READY    = (r_state == IDLE);
  assign OUT_VALID   = r_out_valid;
  assign STATE_R_OUT = r_state_r;
  assign STATE_W_OUT = r_state_w;
  assign ADDR_OUT    = r_addr_out;
  assign DATA_OUT    = r_data_out;
  assign FAIL_OUT    = r_fail_out;
  assign FAIL_IDX    = r_fail_idx;

endmodule

// File: tb/tb_uart_hex_dec.sv
// Bench for uart_hex_dec: two instances (lowercase accepted / rejected) on
// shared inputs, directed table, randomized frames vs. a reference model.
module tb_uart_hex_dec;
  localparam int AC = 2;
  localparam int DC = 8;
  localparam int N  = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic IN_VALID = 1'b0, STATE_R_IN = 1'b0, STATE_W_IN = 1'b0, FAIL_IN = 1'b0, OUT_READY = 1'b0;
  logic [8*AC-1:0] ADDR_IN = '0;
  logic [8*DC-1:0] DATA_IN = '0;

  logic u_in_ready, u_out_valid, u_sr, u_sw, u_fail;
  logic [7:0] u_addr;
  logic [31:0] u_data;
  logic [3:0] u_idx;
  logic l_in_ready, l_out_valid, l_sr, l_sw, l_fail;
  logic [7:0] l_addr;
  logic [31:0] l_data;
  logic [3:0] l_idx;

  int n_vec = 0;
  int n_err = 0;

  uart_hex_dec #(.ADDR_CHARS(AC), .DATA_CHARS(DC), .LOWER_EN(1)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(u_in_ready),
    .STATE_R_IN(STATE_R_IN), .STATE_W_IN(STATE_W_IN), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
    .FAIL_IN(FAIL_IN), .OUT_VALID(u_out_valid), .OUT_READY(OUT_READY),
    .STATE_R_OUT(u_sr), .STATE_W_OUT(u_sw), .ADDR_OUT(u_addr), .DATA_OUT(u_data),
    .FAIL_OUT(u_fail), .FAIL_IDX(u_idx));

  uart_hex_dec #(.ADDR_CHARS(AC), .DATA_CHARS(DC), .LOWER_EN(0)) dut_lc (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(l_in_ready),
    .STATE_R_IN(STATE_R_IN), .STATE_W_IN(STATE_W_IN), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
    .FAIL_IN(FAIL_IN), .OUT_VALID(l_out_valid), .OUT_READY(OUT_READY),
    .STATE_R_OUT(l_sr), .STATE_W_OUT(l_sw), .ADDR_OUT(l_addr), .DATA_OUT(l_data),
    .FAIL_OUT(l_fail), .FAIL_IDX(l_idx));

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
    bit          r, w, fi;
    logic [7:0]  ea, ea_lc;
    logic [31:0] ed, ed_lc;
    bit          ef, ef_lc;
    logic [3:0]  ex, ex_lc;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: value = sum of digit*16^position; non-hex characters count as 0.
  function automatic void model(input logic [15:0] a, input logic [63:0] d, input bit lower,
                                output logic [7:0] ea, output logic [31:0] ed,
                                output bit ef, output logic [3:0] ex);
    logic [79:0] s;
    longint unsigned acc;
    int ci, nib;
    s = {a, d};
    acc = 0;
    ef = 1'b0;
    ex = '0;
    for (int k = 0; k < N; k++) begin
      ci = int'(s[79-8*k -: 8]);
      if (ci >= 48 && ci <= 57) nib = ci - 48;
      else if (ci >= 65 && ci <= 70) nib = ci - 55;
      else if (lower && ci >= 97 && ci <= 102) nib = ci - 87;
      else begin
        nib = 0;
        if (!ef) begin
          ef = 1'b1;
          ex = 4'(k);
        end
      end
      acc = acc * 16 + longint'(nib);
    end
    ea = acc[39:32];
    ed = acc[31:0];
  endfunction

  function automatic logic [7:0] rnd_char();
    string hx;
    hx = "0123456789ABCDEFabcdef";
    if ($urandom_range(0, 3) != 0) return hx[$urandom_range(0, 21)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic run_frame(input logic [15:0] a, input logic [63:0] d, input bit r, input bit w,
                           input bit fi, output int lat);
    int t;
    t = 0;
    while (!u_in_ready && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("in_ready_before_frame", u_in_ready, 1);
    ADDR_IN = a; DATA_IN = d; STATE_R_IN = r; STATE_W_IN = w; FAIL_IN = fi; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; FAIL_IN = 1'b0;
    lat = 0;
    while (!u_out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic check_out(input string nm, input int lat, input vec_t v);
    chk({nm, ".latency"}, lat, v.lat);
    chk({nm, ".lc_valid"}, l_out_valid, 1);
    chk({nm, ".state_r"}, {u_sr, l_sr}, {v.r, v.r});
    chk({nm, ".state_w"}, {u_sw, l_sw}, {v.w, v.w});
    chk({nm, ".fail"}, u_fail, v.ef);
    chk({nm, ".fail_idx"}, u_idx, v.ex);
    chk({nm, ".lc_fail"}, l_fail, v.ef_lc);
    chk({nm, ".lc_fail_idx"}, l_idx, v.ex_lc);
    chk({nm, ".in_ready_busy"}, u_in_ready, 0);
    if (!v.fi) begin
      chk({nm, ".addr"}, u_addr, v.ea);
      chk({nm, ".data"}, u_data, v.ed);
      chk({nm, ".lc_addr"}, l_addr, v.ea_lc);
      chk({nm, ".lc_data"}, l_data, v.ed_lc);
    end
  endtask

  task automatic release_out(input string nm);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    chk({nm, ".ready_after"}, u_in_ready, 1);
    chk({nm, ".valid_after"}, u_out_valid, 0);
  endtask

  vec_t tbl[5];
  vec_t rv;
  int lat, seen;

  initial begin
    tbl[0] = '{a:"1F", d:"DEADBEEF", r:1, w:0, fi:0, ea:8'h1F, ea_lc:8'h1F,
               ed:32'hDEADBEEF, ed_lc:32'hDEADBEEF, ef:0, ef_lc:0, ex:0, ex_lc:0, lat:10};
    tbl[1] = '{a:"a5", d:"0000ffff", r:0, w:1, fi:0, ea:8'hA5, ea_lc:8'h05,
               ed:32'h0000FFFF, ed_lc:32'h00000000, ef:0, ef_lc:1, ex:0, ex_lc:0, lat:10};
    tbl[2] = '{a:"00", d:"123G56:8", r:1, w:1, fi:0, ea:8'h00, ea_lc:8'h00,
               ed:32'h12305608, ed_lc:32'h12305608, ef:1, ef_lc:1, ex:5, ex_lc:5, lat:10};
    tbl[3] = '{a:"ZZ", d:"ZZZZZZZZ", r:1, w:1, fi:1, ea:8'h00, ea_lc:8'h00,
               ed:32'h0, ed_lc:32'h0, ef:1, ef_lc:1, ex:10, ex_lc:10, lat:1};
    tbl[4] = '{a:"9A", d:"@GFfg/09", r:0, w:0, fi:0, ea:8'h9A, ea_lc:8'h9A,
               ed:32'h00FF0009, ed_lc:32'h00F00009, ef:1, ef_lc:1, ex:2, ex_lc:2, lat:10};

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset.in_ready", {u_in_ready, l_in_ready}, 2'b11);
    chk("reset.out_valid", {u_out_valid, l_out_valid}, 2'b00);
    chk("reset.outputs", {u_sr, u_sw, u_addr, u_data, u_fail, u_idx}, 0);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].w, tbl[i].fi, lat);
      check_out($sformatf("table%0d", i), lat, tbl[i]);
      release_out($sformatf("table%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 2; k++) rv.a[8*k +: 8] = rnd_char();
      for (int k = 0; k < 8; k++) rv.d[8*k +: 8] = rnd_char();
      rv.r  = 1'($urandom_range(0, 1));
      rv.w  = 1'($urandom_range(0, 1));
      rv.fi = ($urandom_range(0, 7) == 0);
      model(rv.a, rv.d, 1'b1, rv.ea, rv.ed, rv.ef, rv.ex);
      model(rv.a, rv.d, 1'b0, rv.ea_lc, rv.ed_lc, rv.ef_lc, rv.ex_lc);
      if (rv.fi) begin
        rv.ef = 1'b1; rv.ex = 4'd10; rv.ef_lc = 1'b1; rv.ex_lc = 4'd10; rv.lat = 1;
      end else begin
        rv.lat = 10;
      end
      run_frame(rv.a, rv.d, rv.r, rv.w, rv.fi, lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
      end
      check_out($sformatf("rand%0d", i), lat, rv);
      release_out($sformatf("rand%0d", i));
    end

    // Backpressure: result must hold while a competing frame is offered.
    rv = '{a:"3C", d:"01234567", r:0, w:1, fi:0, ea:8'h3C, ea_lc:8'h3C,
           ed:32'h01234567, ed_lc:32'h01234567, ef:0, ef_lc:0, ex:0, ex_lc:0, lat:10};
    run_frame(rv.a, rv.d, rv.r, rv.w, rv.fi, lat);
    check_out("stall", lat, rv);
    ADDR_IN = "77"; DATA_IN = "89ABCDEF"; STATE_R_IN = 1'b1; STATE_W_IN = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("stall.valid_held", u_out_valid, 1);
      chk("stall.outputs_held", {u_addr, u_data, u_fail, u_idx, u_sw}, {8'h3C, 32'h01234567, 1'b0, 4'd0, 1'b1});
      chk("stall.in_ready_low", u_in_ready, 0);
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    IN_VALID = 1'b0;
    chk("stall.ready_after", u_in_ready, 1);
    chk("stall.valid_after", u_out_valid, 0);
    chk("stall.outputs_kept", {u_addr, u_data}, {8'h3C, 32'h01234567});
    rv = '{a:"77", d:"89ABCDEF", r:1, w:0, fi:0, ea:8'h77, ea_lc:8'h77,
           ed:32'h89ABCDEF, ed_lc:32'h89ABCDEF, ef:0, ef_lc:0, ex:0, ex_lc:0, lat:10};
    run_frame(rv.a, rv.d, rv.r, rv.w, rv.fi, lat);
    check_out("second", lat, rv);
    release_out("second");

    // Reset in the middle of a conversion (counter at 4).
    ADDR_IN = "12"; DATA_IN = "34567890"; STATE_R_IN = 1'b1; STATE_W_IN = 1'b1; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort.in_ready", {u_in_ready, l_in_ready}, 2'b11);
    chk("abort.out_valid", {u_out_valid, l_out_valid}, 2'b00);
    chk("abort.outputs", {u_sr, u_sw, u_addr, u_data, u_fail, u_idx}, 0);
    chk("abort.lc_outputs", {l_sr, l_sw, l_addr, l_data, l_fail, l_idx}, 0);
    seen = 0;
    repeat (15) begin
      @(posedge CLK); #1;
      if (u_out_valid || l_out_valid) seen = 1;
    end
    chk("abort.no_result", seen, 0);

    rv = '{a:"E0", d:"0F0F0F0F", r:0, w:1, fi:0, ea:8'hE0, ea_lc:8'hE0,
           ed:32'h0F0F0F0F, ed_lc:32'h0F0F0F0F, ef:0, ef_lc:0, ex:0, ex_lc:0, lat:10};
    run_frame(rv.a, rv.d, rv.r, rv.w, rv.fi, lat);
    check_out("recover", lat, rv);
    release_out("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
